// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 definitions for the fetch slice: instruction codes, the
// status encoding reported with every fetch bundle, the fetch state machine
// encoding and the "no register" marker used for unused ra/rb fields.
// No ports; imported by y86_instr_len and y86_fetch_unit.
// ---------------------------------------------------------------------------
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  // Longest encoding (irmovq/rmmovq/mrmovq) is ten bytes.
  localparam int MAX_INSTR_BYTES = 10;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/y86_instr_len.sv
// ---------------------------------------------------------------------------
// y86_instr_len
// Purely combinational classifier for a Y86-64 opcode byte. Kept apart from
// the fetch unit so decode-side checks can reuse the same table.
// Ports:
//   icode_i        instruction code (upper nibble of byte 0)
//   ifun_i         function code (lower nibble of byte 0)
//   len_o          encoded length in bytes (1, 2, 9 or 10)
//   need_regids_o  a register-specifier byte follows the opcode
//   need_valc_o    an 8-byte constant word is present
//   instr_valid_o  icode/ifun pair is a legal instruction
// Illegal icodes report length 1 so the caller still has a sane valp.
// ---------------------------------------------------------------------------
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  input  logic [3:0] ifun_i,
  output logic [3:0] len_o,
  output logic       need_regids_o,
  output logic       need_valc_o,
  output logic       instr_valid_o
);

  always_comb begin
    len_o         = 4'd1;
    need_regids_o = 1'b0;
    need_valc_o   = 1'b0;
    instr_valid_o = 1'b1;
    case (icode_i)
      I_HALT, I_NOP, I_RET: begin
        instr_valid_o = (ifun_i == 4'h0);
      end
      I_RRMOVQ: begin
        // rrmovq plus the six conditional moves share icode 2.
        len_o         = 4'd2;
        need_regids_o = 1'b1;
        instr_valid_o = (ifun_i <= 4'h6);
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        len_o         = 4'd10;
        need_regids_o = 1'b1;
        need_valc_o   = 1'b1;
        instr_valid_o = (ifun_i == 4'h0);
      end
      I_OPQ: begin
        len_o         = 4'd2;
        need_regids_o = 1'b1;
        instr_valid_o = (ifun_i <= 4'h3);
      end
      I_JXX: begin
        len_o         = 4'd9;
        need_valc_o   = 1'b1;
        instr_valid_o = (ifun_i <= 4'h6);
      end
      I_CALL: begin
        len_o         = 4'd9;
        need_valc_o   = 1'b1;
        instr_valid_o = (ifun_i == 4'h0);
      end
      I_PUSHQ, I_POPQ: begin
        len_o         = 4'd2;
        need_regids_o = 1'b1;
        instr_valid_o = (ifun_i == 4'h0);
      end
      default: begin
        instr_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// ---------------------------------------------------------------------------
// y86_fetch_unit
// Y86-64 fetch stage: owns the PC and a byte-addressed instruction memory,
// decodes the variable-length encoding of the instruction at PC and hands a
// registered bundle to decode over a valid/ready handshake. Later stages may
// redirect the PC. A non-AOK bundle stops fetching; once it is accepted the
// unit parks in HALTED until reset.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   imem_we/imem_waddr/imem_wdata   byte load port (works in every state)
//   redir_valid/redir_pc            PC redirect from a later stage
//   out_ready                       decode accepts the bundle
//   out_valid, out_pc, icode, ifun, ra, rb, valc, valp, pred_pc, stat
//                                   registered fetch bundle
//   halted                          fetch has stopped
// Build option: define FETCH_PREDICT_EN to predict jXX/call targets from
// valc; otherwise the next fetch is always valp.
// ---------------------------------------------------------------------------
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int              IMEM_BYTES = 1024,
  parameter int              PC_W       = 64,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            imem_we,
  input  logic [PC_W-1:0] imem_waddr,
  input  logic [7:0]      imem_wdata,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      icode,
  output logic [3:0]      ifun,
  output logic [3:0]      ra,
  output logic [3:0]      rb,
  output logic [63:0]     valc,
  output logic [PC_W-1:0] valp,
  output logic [PC_W-1:0] pred_pc,
  output logic [1:0]      stat,
  output logic            halted
);

  localparam int              AW         = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [PC_W-1:0] IMEM_LIMIT = PC_W'(IMEM_BYTES);

  logic [7:0] imem_q [IMEM_BYTES];

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic            out_valid_q;
  logic [PC_W-1:0] out_pc_q;
  logic [3:0]      icode_q;
  logic [3:0]      ifun_q;
  logic [3:0]      ra_q;
  logic [3:0]      rb_q;
  logic [63:0]     valc_q;
  logic [PC_W-1:0] valp_q;
  logic [PC_W-1:0] pred_pc_q;
  stat_e           stat_q;
  logic            halted_q;

  // Memory has no reset so a program can be loaded while the core is held
  // in reset. Out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (imem_we && (imem_waddr < IMEM_LIMIT)) begin
      imem_q[imem_waddr[AW-1:0]] <= imem_wdata;
    end
  end

  // Ten-byte combinational window starting at PC. Bytes past the end of
  // memory read as zero; the ADR check below decides whether they matter.
  logic [7:0] fbyte [MAX_INSTR_BYTES];

  for (genvar k = 0; k < MAX_INSTR_BYTES; k++) begin : g_rd
    logic [PC_W-1:0] rdAddr;
    assign rdAddr   = pc_q + PC_W'(k);
    assign fbyte[k] = (rdAddr < IMEM_LIMIT) ? imem_q[rdAddr[AW-1:0]] : 8'h00;
  end

  logic [3:0] icode_d;
  logic [3:0] ifun_d;
  logic [3:0] len_d;
  logic       need_regids_d;
  logic       need_valc_d;
  logic       instr_valid_d;

  assign icode_d = fbyte[0][7:4];
  assign ifun_d  = fbyte[0][3:0];

  y86_instr_len u_len (
    .icode_i       (icode_d),
    .ifun_i        (ifun_d),
    .len_o         (len_d),
    .need_regids_o (need_regids_d),
    .need_valc_o   (need_valc_d),
    .instr_valid_o (instr_valid_d)
  );

  logic [3:0]      ra_d;
  logic [3:0]      rb_d;
  logic [63:0]     valc_d;
  logic [PC_W-1:0] len_ext;
  logic [PC_W-1:0] valp_d;
  logic [PC_W-1:0] last_addr;
  logic [PC_W-1:0] pred_pc_d;
  stat_e           stat_d;

  assign ra_d = need_regids_d ? fbyte[1][7:4] : REG_NONE;
  assign rb_d = need_regids_d ? fbyte[1][3:0] : REG_NONE;

  // The constant word is little-endian and starts right after the register
  // byte when one is present, otherwise right after the opcode byte.
  assign valc_d = !need_valc_d ? 64'h0 :
                  need_regids_d ? {fbyte[9], fbyte[8], fbyte[7], fbyte[6],
                                   fbyte[5], fbyte[4], fbyte[3], fbyte[2]}
                                : {fbyte[8], fbyte[7], fbyte[6], fbyte[5],
                                   fbyte[4], fbyte[3], fbyte[2], fbyte[1]};

  assign len_ext   = {{(PC_W-4){1'b0}}, len_d};
  assign valp_d    = pc_q + len_ext;
  assign last_addr = pc_q + len_ext - PC_W'(1);

`ifdef FETCH_PREDICT_EN
  assign pred_pc_d = ((icode_d == I_JXX) || (icode_d == I_CALL)) ? PC_W'(valc_d) : valp_d;
`else
  assign pred_pc_d = valp_d;
`endif

  // The first-byte test catches a PC so large that last_addr wraps around.
  always_comb begin
    stat_d = STAT_AOK;
    if ((pc_q >= IMEM_LIMIT) || (last_addr >= IMEM_LIMIT)) begin
      stat_d = STAT_ADR;
    end else if (!instr_valid_d) begin
      stat_d = STAT_INS;
    end else if (icode_d == I_HALT) begin
      stat_d = STAT_HLT;
    end
  end

  // Fetch FSM and output register. A non-AOK bundle sitting in the output
  // register blocks further fetches; the unit only moves to HALTED once
  // decode takes it, so a redirect arriving first can still squash it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FS_RUN;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      icode_q     <= 4'h0;
      ifun_q      <= 4'h0;
      ra_q        <= REG_NONE;
      rb_q        <= REG_NONE;
      valc_q      <= 64'h0;
      valp_q      <= '0;
      pred_pc_q   <= '0;
      stat_q      <= STAT_AOK;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        FS_RUN: begin
          if (redir_valid) begin
            pc_q        <= redir_pc;
            out_valid_q <= 1'b0;
          end else if (out_valid_q && (stat_q != STAT_AOK)) begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              state_q     <= FS_HALTED;
              halted_q    <= 1'b1;
            end
          end else if (!out_valid_q || out_ready) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= pc_q;
            icode_q     <= icode_d;
            ifun_q      <= ifun_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            valc_q      <= valc_d;
            valp_q      <= valp_d;
            pred_pc_q   <= pred_pc_d;
            stat_q      <= stat_d;
            pc_q        <= pred_pc_d;
          end
        end
        FS_HALTED: begin
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q <= FS_HALTED;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign ra        = ra_q;
  assign rb        = rb_q;
  assign valc      = valc_q;
  assign valp      = valp_q;
  assign pred_pc   = pred_pc_q;
  assign stat      = stat_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_y86_fetch_unit
// Directed bench for y86_fetch_unit: small programs are loaded through the
// load port while the core sits in reset, then bundles are compared against
// hand-computed fields one cycle at a time. Honours FETCH_PREDICT_EN.
// ---------------------------------------------------------------------------
module tb_y86_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [7:0]  imem_wdata;
  logic        redir_valid;
  logic [63:0] redir_pc;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [63:0] valc;
  logic [63:0] valp;
  logic [63:0] pred_pc;
  logic [1:0]  stat;
  logic        halted;

  int passCount;
  int checkCount;

  logic [63:0] expJmpNext;

  y86_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .icode       (icode),
    .ifun        (ifun),
    .ra          (ra),
    .rb          (rb),
    .valc        (valc),
    .valp        (valp),
    .pred_pc     (pred_pc),
    .stat        (stat),
    .halted      (halted)
  );

  // 10 ns clock; everything is driven and sampled 1 ns after a rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the run ever stops advancing.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives the control inputs for the next rising edge and steps past it.
  task automatic applyStimulus(input logic rstN, input logic ready,
                               input logic redirV, input logic [63:0] redirPc);
    rst_n       = rstN;
    out_ready   = ready;
    redir_valid = redirV;
    redir_pc    = redirPc;
    tick();
  endtask

  task automatic writeByte(input logic [63:0] addr, input logic [7:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    tick();
    imem_we    = 1'b0;
  endtask

  initial begin
    passCount   = 0;
    checkCount  = 0;
    rst_n       = 1'b0;
    imem_we     = 1'b0;
    imem_waddr  = '0;
    imem_wdata  = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    out_ready   = 1'b0;
`ifdef FETCH_PREDICT_EN
    expJmpNext = 64'h40;
`else
    expJmpNext = 64'h9;
`endif

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("rst_valid",  out_valid, 64'h0);
    checkOutput("rst_ra",     ra,        64'hF);
    checkOutput("rst_rb",     rb,        64'hF);
    checkOutput("rst_halted", halted,    64'h0);
    checkOutput("rst_stat",   stat,      64'h0);
    checkOutput("rst_valp",   valp,      64'h0);

    // irmovq $0x123, %rbx ; halt
    writeByte(64'd0, 8'h30);
    writeByte(64'd1, 8'hF3);
    writeByte(64'd2, 8'h23);
    writeByte(64'd3, 8'h01);
    for (int i = 4; i < 10; i++) writeByte(64'(i), 8'h00);
    writeByte(64'd10, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("irm_valid", out_valid, 64'h1);
    checkOutput("irm_pc",    out_pc,    64'h0);
    checkOutput("irm_icode", icode,     64'h3);
    checkOutput("irm_ra",    ra,        64'hF);
    checkOutput("irm_rb",    rb,        64'h3);
    checkOutput("irm_valc",  valc,      64'h123);
    checkOutput("irm_valp",  valp,      64'd10);
    checkOutput("irm_stat",  stat,      64'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("hlt_valid", out_valid, 64'h1);
    checkOutput("hlt_pc",    out_pc,    64'd10);
    checkOutput("hlt_stat",  stat,      64'h1);
    checkOutput("hlt_valp",  valp,      64'd11);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("hlt_halted",  halted,    64'h1);
    checkOutput("hlt_cleared", out_valid, 64'h0);
    // Redirect must be ignored once halted
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h300);
    checkOutput("hlt_redir_valid", out_valid,  64'h0);
    checkOutput("hlt_redir_pc",    dut.pc_q,   64'd11);
    checkOutput("hlt_redir_halt",  halted,     64'h1);

    // Reset while halted, then fetch resumes from RESET_PC
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput("rh_valid",  out_valid, 64'h0);
    checkOutput("rh_halted", halted,    64'h0);
    checkOutput("rh_pc",     dut.pc_q,  64'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("rh_resume_valid", out_valid, 64'h1);
    checkOutput("rh_resume_pc",    out_pc,    64'h0);
    checkOutput("rh_resume_icode", icode,     64'h3);

    // nop ; nop ; addq %rcx,%rdx ; halt  with a three-cycle stall
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    writeByte(64'd0, 8'h10);
    writeByte(64'd1, 8'h10);
    writeByte(64'd2, 8'h60);
    writeByte(64'd3, 8'h12);
    writeByte(64'd4, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    checkOutput("nop0_pc",   out_pc, 64'd0);
    checkOutput("nop0_valp", valp,   64'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
      checkOutput("stall_valid", out_valid, 64'h1);
      checkOutput("stall_pc",    out_pc,    64'd0);
      checkOutput("stall_valp",  valp,      64'd1);
    end
    checkOutput("stall_pcreg", dut.pc_q, 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("nop1_pc",   out_pc, 64'd1);
    checkOutput("nop1_valp", valp,   64'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("opq_pc",    out_pc, 64'd2);
    checkOutput("opq_valp",  valp,   64'd4);
    checkOutput("opq_icode", icode,  64'h6);
    checkOutput("opq_ra",    ra,     64'h1);
    checkOutput("opq_rb",    rb,     64'h2);
    checkOutput("opq_valc",  valc,   64'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("opq_hlt_pc",   out_pc, 64'd4);
    checkOutput("opq_hlt_stat", stat,   64'h1);

    // jmp 0x40 ; target and fall-through both hold halt
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    writeByte(64'd0, 8'h70);
    writeByte(64'd1, 8'h40);
    for (int i = 2; i < 10; i++) writeByte(64'(i), 8'h00);
    writeByte(64'h40, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("jmp_icode", icode,   64'h7);
    checkOutput("jmp_ra",    ra,      64'hF);
    checkOutput("jmp_valc",  valc,    64'h40);
    checkOutput("jmp_valp",  valp,    64'd9);
    checkOutput("jmp_pred",  pred_pc, expJmpNext);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("jmp_next_pc",   out_pc, expJmpNext);
    checkOutput("jmp_next_stat", stat,   64'h1);

    // Redirect during a stall, then redirect squashing a halt bundle
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    writeByte(64'd0, 8'h10);
    writeByte(64'h20, 8'h20);
    writeByte(64'h21, 8'h12);
    writeByte(64'h22, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    checkOutput("rd_first_pc", out_pc, 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h20);
    checkOutput("rd_squash", out_valid, 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    checkOutput("rd_valid", out_valid, 64'h1);
    checkOutput("rd_pc",    out_pc,    64'h20);
    checkOutput("rd_icode", icode,     64'h2);
    checkOutput("rd_ra",    ra,        64'h1);
    checkOutput("rd_rb",    rb,        64'h2);
    checkOutput("rd_valp",  valp,      64'h22);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("rd_hlt_pc",   out_pc, 64'h22);
    checkOutput("rd_hlt_stat", stat,   64'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h0);
    checkOutput("rd_hsq_valid",  out_valid, 64'h0);
    checkOutput("rd_hsq_halted", halted,    64'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("rd_hsq_refetch", out_valid, 64'h1);
    checkOutput("rd_hsq_pc",      out_pc,    64'h0);
    checkOutput("rd_hsq_icode",   icode,     64'h1);

    // Illegal icode 0xC
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    writeByte(64'd0, 8'hC0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("ins_valid", out_valid, 64'h1);
    checkOutput("ins_stat",  stat,      64'h3);
    checkOutput("ins_icode", icode,     64'hC);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("ins_halted", halted,    64'h1);
    checkOutput("ins_clear",  out_valid, 64'h0);

    // OPq with ifun 4 is out of range
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    writeByte(64'd0, 8'h64);
    writeByte(64'd1, 8'h12);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("ifun_stat", stat, 64'h3);
    checkOutput("ifun_ifun", ifun, 64'h4);
    checkOutput("ifun_valp", valp, 64'd2);

    // irmovq starting five bytes before the end of memory
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    writeByte(64'd1019, 8'h30);
    writeByte(64'd1020, 8'hF1);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'd1019);
    checkOutput("adr_squash", out_valid, 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("adr_valid", out_valid, 64'h1);
    checkOutput("adr_stat",  stat,      64'h2);
    checkOutput("adr_pc",    out_pc,    64'd1019);
    checkOutput("adr_valp",  valp,      64'd1029);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("adr_halted", halted, 64'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/y86_fetch_unit.md
Name: y86_fetch_unit

Overview:
- Parametrised successor to the single-cycle Y86-64 fetch stage.
- Holds a byte-addressed instruction memory with a load port, and owns the PC register.
- Each fetched instruction is decoded into variable-length fields, computing its own length (1, 2, 9 or 10 bytes).
- Results go to decode through a valid/ready output register, with later-stage PC redirect, status reporting and a halt state machine.

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes.
- PC_W, 64, PC / address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- imem_we  in  1  byte write enable for the load port.
- imem_waddr  in  PC_W  byte write address.
- imem_wdata  in  8  byte write data.
- redir_valid  in  1  PC redirect request from a later stage (mispredict/ret).
- redir_pc  in  PC_W  redirect target.
- out_ready  in  1  decode can accept.
- out_valid  out  1  fetch bundle valid.
- out_pc  out  PC_W  address of the fetched instruction.
- icode  out  4  instruction code.
- ifun  out  4  function code.
- ra  out  4  register A (0xF if unused).
- rb  out  4  register B (0xF if unused).
- valc  out  64  constant word, little-endian.
- valp  out  PC_W  out_pc + length.
- pred_pc  out  PC_W  next-fetch address chosen.
- stat  out  2  0=AOK, 1=HLT, 2=ADR, 3=INS.
- halted  out  1  fetch has stopped.

Behaviour:
- Reset (rst_n=0 at posedge): PC=RESET_PC, state=RUN, out_valid=0, all outputs=0 except ra=rb=0xF, halted=0. Memory contents are not cleared.
- States:
  - RUN: fetches.
  - HALTED: stops; only reset leaves it.
- Fetch fires in RUN when (!out_valid || out_ready) && !redir_valid.
  - Bytes at PC..PC+9 are read combinationally.
  - The output register updates at posedge with out_valid=1.
  - PC <= pred_pc.
  - Latency: one cycle from PC to bundle.
- Stall: out_valid && !out_ready holds every output and the PC unchanged.
- Lengths:
  - 0x0, 0x1, 0x9 → 1 byte.
  - 0x2, 0x6, 0xA, 0xB → 2 bytes (register byte).
  - 0x7, 0x8 → 9 bytes (valc = bytes 1..8).
  - 0x3, 0x4, 0x5 → 10 bytes (register byte + valc = bytes 2..9).
  - Unused valc = 0.
- Register byte: ra = byte[7:4], rb = byte[3:0].
- Status:
  - icode > 0xB, or ifun out of range (cmov/jXX > 6, OPq > 3, others ≠ 0) → INS.
  - Any byte PC..PC+len-1 ≥ IMEM_BYTES → ADR. ADR has priority over INS.
  - icode 0 → HLT.
  - Any non-AOK status is emitted once with out_valid=1; the next state is HALTED, halted=1, and out_valid clears after acceptance.
- Arithmetic: valp = PC + len, modulo 2^PC_W (wraps, no error).
- Redirect: redir_valid in RUN at posedge → PC <= redir_pc, out_valid <= 0 (squash). It has priority over fetch, over stall, and over an in-flight halt/error bundle (state stays RUN). Redirect is ignored in HALTED.
- Load port: write occurs at posedge. A same-cycle fetch of the same byte sees the old value. Writes are accepted in every state, including during reset.
- Reset mid-stall or mid-halt: all state returns to reset values at the next posedge.

Optional Feature:
- FETCH_PREDICT_EN defined: pred_pc = valc for jXX (all ifun) and call; pred_pc = valp otherwise.
- Undefined: pred_pc = valp always; redirect alone corrects control flow.
- ret always predicts valp in both builds.

Decomposition:
- Package y86_pkg:
  - icode constants (I_HALT..I_POPQ).
  - stat enum (STAT_AOK/HLT/ADR/INS).
  - Fetch state enum.
  - REG_NONE = 4'hF.
- Sub-module y86_instr_len: combinational icode/ifun → length, need_regids, need_valc, instr_valid. Keep it separate for reuse by decode checks.

Test Plan:
- Load `30 F3 <0x0000000000000123 LE>` at 0, then `00` at 10; hold out_ready=1 → first bundle icode=3, rb=3, ra=F, valc=0x123, valp=10; second bundle stat=HLT; halted=1 thereafter, PC stays 11.
- nop, nop, OPq `60 12` at 0..3, out_ready=0 for 3 cycles after the first bundle → first bundle held stable; after release, sequence PCs 0, 1, 2 with valp 1, 2, 4.
- jXX `70 <0x40>` at 0 with FETCH_PREDICT_EN → next out_pc=0x40. Without the macro → next out_pc=9.
- redir_valid with redir_pc=0x20 during a stall → out_valid=0 next cycle, then a bundle with out_pc=0x20.
- Byte 0xC0 at 0 → stat=INS, halted. irmov at IMEM_BYTES-5 → stat=ADR.
- Assert rst_n=0 while HALTED → next cycle out_valid=0, PC=RESET_PC, and fetch resumes after release.
